k005297_slot_scheduler: RTL and testbench
=========================================

Name: k005297_slot_scheduler

Overview:
- Schedules the shared bubble-memory data path between three requesters:
  - req 0: bubble DMA
  - req 1: host CPU
  - req 2: housekeeping (page/loop maintenance)
- Grants are time-sliced against the 20-step subclock rotator.
- Issues a subclock stop request after the path has been idle for a programmable number of rotator frames, and withdraws it on the first new request.
- Sits beside the supervisor: consumes the rotator, subclock enables and run flag; drives one subclock stop-request input.

Parameters:
- IDLE_FRAMES, 2: idle full frames (20 subclock ticks each) before stop is requested; legal range 1..15.
- CNT_W, 4: width of the idle-frame counter; must hold IDLE_FRAMES.

Ports:
- i_MCLK  in  1  master clock; all state changes on its rising edge.
- i_MRST_n  in  1  synchronous active-low reset, sampled on every i_MCLK edge regardless of enables.
- i_CLK4M_PCEN_n  in  1  4 MHz clock enable, active low; drives only the wake logic.
- i_CLK2M_PCEN_n  in  1  2 MHz subclock enable, active low ("tick"); drives all scheduling state.
- i_ROT20_n  in  20  one-cold rotator position; bit k low = position k.
- i_SYS_RUN_FLAG  in  1  system running; low forces scheduler idle.
- i_REQ  in  3  level requests; bit n = requester n.
- i_LOCK  in  3  per-requester hold of the current grant past a slot boundary.
- o_GNT  out  3  one-hot (or zero) grant.
- o_SLOT_STB  out  1  one-tick pulse on the first tick of a new grant.
- o_BUSY  out  1  high while any grant is active.
- o_CLK2M_STOPRQ_n  out  1  low requests subclock stop; goes to the supervisor stop-request input.

Behaviour:
- Reset values: o_GNT=000, o_SLOT_STB=0, o_BUSY=0, o_CLK2M_STOPRQ_n=1, state IDLE, idle counter 0, round-robin pointer = host (host wins the first tie).
- Position decode: pos = index of the single low bit of i_ROT20_n. valid = exactly one bit low. An invalid pattern is never an arbitration point.
- Arbitration points: valid pos in {0,5,10,15} on a tick. Each slot is 5 ticks.
- States: IDLE, OWN, STOPPED.
- IDLE -> OWN, at an arbitration point with any i_REQ bit set:
  - DMA (bit 0) wins outright.
  - Otherwise host/housekeeping alternate round-robin; the pointer flips to the other requester after each grant to either.
  - The grant register loads on that tick; o_SLOT_STB=1 for that tick only.
- OWN, at the next arbitration point:
  - If the owner holds i_LOCK and i_REQ, the grant is kept with no strobe.
  - Otherwise re-arbitrate. The same requester may win again; that is a new grant and pulses o_SLOT_STB.
  - If no request is pending, go to IDLE and set o_GNT=000.
- OWN, mid-slot: if the owner drops i_REQ, o_GNT clears on the next tick and the state goes to IDLE. No new grant is issued before the next arbitration point.
- Latency:
  - Request to grant: at most 5 ticks, plus a 20-tick frame wait if i_ROT20_n is invalid.
  - Grant withdrawal: 1 tick.
- Idle count:
  - In IDLE, the counter increments on each tick with valid pos=19.
  - Any request clears it.
  - Saturates at IDLE_FRAMES.
  - On reaching IDLE_FRAMES: o_CLK2M_STOPRQ_n <= 0; state -> STOPPED.
- STOPPED: subclock ticks may cease. The wake logic runs on i_CLK4M_PCEN_n:
  - The first 4 MHz enable with any i_REQ set drives o_CLK2M_STOPRQ_n <= 1, clears the counter, and sets state IDLE.
  - No grant is issued until a later tick at an arbitration point.
- i_SYS_RUN_FLAG low, checked on either enable:
  - State IDLE, o_GNT=000, counter 0, o_CLK2M_STOPRQ_n=1.
  - Takes priority over every transition except reset.
- Simultaneous events on one tick:
  - Owner drops i_REQ exactly at an arbitration point: re-arbitrate normally with the owner excluded.
  - Wake and tick in the same i_MCLK cycle: wake applies; scheduling waits for the next tick.
- Reset mid-grant: o_GNT drops to 000 on the next i_MCLK edge. No strobe is emitted.
- o_BUSY = |o_GNT, registered together with o_GNT.

Decomposition:
- Shared package k005297_pkg:
  - state enum {IDLE, OWN, STOPPED}
  - requester index constants REQ_DMA=0, REQ_HOST=1, REQ_HK=2
  - SLOT_LEN=5, FRAME_LEN=20
- Sub-module k005297_rot20_decode: combinational. Converts one-cold 20-bit input to a 5-bit pos plus valid. Reusable by other rotator consumers.

Test Plan:
- Reset, then host and housekeeping requesting continuously from pos 3 -> host granted at pos 5, housekeeping at pos 10, host at pos 15, each with a single o_SLOT_STB; DMA never granted.
- DMA and host requested at pos 0 -> o_GNT=001 for pos 0..4; at pos 5 DMA dropped -> o_GNT=010 at pos 5 with strobe.
- Host granted at pos 10 with i_LOCK[1]=1 through pos 15 -> o_GNT stays 010 at pos 15 with no strobe; DMA request at pos 15 still loses until the lock drops.
- IDLE_FRAMES=2, no requests -> o_CLK2M_STOPRQ_n falls on the tick after the second pos=19. Gate ticks off and raise i_REQ[2] -> o_CLK2M_STOPRQ_n=1 on the next 4 MHz enable.
- Host owns the grant; drive i_ROT20_n=all ones for 10 ticks -> no re-arbitration and no strobe; i_MRST_n low for one i_MCLK -> o_GNT=000, o_BUSY=0 on the next edge.
- i_SYS_RUN_FLAG low while DMA owns and stop is pending -> o_GNT=000 and o_CLK2M_STOPRQ_n=1 on the next enable edge.

Source files
------------

// File: rtl/k005297_pkg.sv
// Shared types and constants for the K005297 slot scheduler and its rotator consumers.
// Holds the scheduler state, the requester indices, the rotator geometry and the arbitration helper.
package k005297_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    STOPPED = 2'd2
  } sched_state_t;

  localparam int REQ_DMA  = 0;
  localparam int REQ_HOST = 1;
  localparam int REQ_HK   = 2;

  localparam int SLOT_LEN  = 5;
  localparam int FRAME_LEN = 20;

  // DMA always wins; host and housekeeping share the remainder by alternating turns.
  function automatic logic [2:0] pick_winner(input logic [2:0] req, input logic hk_turn);
    logic [2:0] win;
    win = '0;
    if (req[REQ_DMA]) begin
      win[REQ_DMA] = 1'b1;
    end else if (req[REQ_HOST] && req[REQ_HK]) begin
      if (hk_turn) win[REQ_HK] = 1'b1;
      else         win[REQ_HOST] = 1'b1;
    end else if (req[REQ_HOST]) begin
      win[REQ_HOST] = 1'b1;
    end else if (req[REQ_HK]) begin
      win[REQ_HK] = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/k005297_rot20_decode.sv
// One-cold 20-step rotator decoder: reports the position of the single low bit.
// Any pattern without exactly one low bit is flagged invalid so consumers can ignore it.
module k005297_rot20_decode
  import k005297_pkg::*;
(
  input  logic [FRAME_LEN-1:0] rot_n,
  output logic [4:0]           pos,
  output logic                 valid
);

  logic [4:0] low_cnt;

  always_comb begin
    pos     = '0;
    low_cnt = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (!rot_n[k]) begin
        pos     = 5'(k);
        low_cnt = low_cnt + 5'd1;
      end
    end
    valid = (low_cnt == 5'd1);
  end

endmodule

// File: rtl/k005297_slot_scheduler.sv
// Time-sliced grant scheduler for the shared bubble-memory data path (DMA, host, housekeeping).
// Requests a subclock stop after a run of idle frames and withdraws it on the first new request.
module k005297_slot_scheduler
  import k005297_pkg::*;
#(
  parameter int IDLE_FRAMES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                 i_MCLK,
  input  logic                 i_MRST_n,
  input  logic                 i_CLK4M_PCEN_n,
  input  logic                 i_CLK2M_PCEN_n,
  input  logic [FRAME_LEN-1:0] i_ROT20_n,
  input  logic                 i_SYS_RUN_FLAG,
  input  logic [2:0]           i_REQ,
  input  logic [2:0]           i_LOCK,
  output logic [2:0]           o_GNT,
  output logic                 o_SLOT_STB,
  output logic                 o_BUSY,
  output logic                 o_CLK2M_STOPRQ_n
);

  sched_state_t     state;
  logic [2:0]       gnt;
  logic             slot_stb;
  logic             busy;
  logic             stoprq_n;
  logic [CNT_W-1:0] idle_cnt;
  logic             hk_turn;

  logic             tick;
  logic             wake;
  logic [4:0]       pos;
  logic             pos_valid;
  logic             arb_point;
  logic             frame_end;
  logic             any_req;
  logic [2:0]       winner;
  logic             owner_req;
  logic             owner_locked;
  logic             rearb;
  logic [CNT_W-1:0] cnt_next;

  k005297_rot20_decode u_decode (
    .rot_n (i_ROT20_n),
    .pos   (pos),
    .valid (pos_valid)
  );

  assign tick      = ~i_CLK2M_PCEN_n;
  assign wake      = ~i_CLK4M_PCEN_n;
  assign any_req   = |i_REQ;
  assign arb_point = pos_valid && (pos == 5'(0) || pos == 5'(SLOT_LEN) ||
                                   pos == 5'(2 * SLOT_LEN) || pos == 5'(3 * SLOT_LEN));
  assign frame_end = pos_valid && (pos == 5'(FRAME_LEN - 1));

  assign winner       = pick_winner(i_REQ, hk_turn);
  assign owner_req    = |(gnt & i_REQ);
  assign owner_locked = |(gnt & i_LOCK & i_REQ);
  assign rearb        = tick && arb_point && any_req &&
                        (state == IDLE || (state == OWN && !owner_locked));
  assign cnt_next     = (idle_cnt >= CNT_W'(IDLE_FRAMES)) ? idle_cnt : idle_cnt + CNT_W'(1);

  // The run flag beats everything but reset; STOPPED only listens to the 4 MHz wake enable.
  always_ff @(posedge i_MCLK) begin
    if (!i_MRST_n) begin
      state    <= IDLE;
      gnt      <= '0;
      slot_stb <= 1'b0;
      busy     <= 1'b0;
      stoprq_n <= 1'b1;
      idle_cnt <= '0;
      hk_turn  <= 1'b0;
    end else if (!i_SYS_RUN_FLAG && (tick || wake)) begin
      state    <= IDLE;
      gnt      <= '0;
      slot_stb <= 1'b0;
      busy     <= 1'b0;
      stoprq_n <= 1'b1;
      idle_cnt <= '0;
    end else begin
      if (tick) slot_stb <= 1'b0;
      case (state)
        STOPPED: begin
          if (wake && any_req) begin
            stoprq_n <= 1'b1;
            idle_cnt <= '0;
            state    <= IDLE;
          end
        end
        IDLE, OWN: begin
          if (tick) begin
            if (any_req) idle_cnt <= '0;
            if (rearb) begin
              gnt      <= winner;
              busy     <= 1'b1;
              slot_stb <= 1'b1;
              state    <= OWN;
              if (winner[REQ_HOST])    hk_turn <= 1'b1;
              else if (winner[REQ_HK]) hk_turn <= 1'b0;
            end else if (state == OWN && ((arb_point && !owner_locked) || !owner_req)) begin
              gnt   <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (state == IDLE && !any_req && frame_end) begin
              idle_cnt <= cnt_next;
              if (cnt_next == CNT_W'(IDLE_FRAMES)) begin
                stoprq_n <= 1'b0;
                state    <= STOPPED;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_GNT            = gnt;
  assign o_SLOT_STB       = slot_stb;
  assign o_BUSY           = busy;
  assign o_CLK2M_STOPRQ_n = stoprq_n;

endmodule

// File: tb/tb_k005297_slot_scheduler.sv
// Directed self-checking bench for k005297_slot_scheduler; each task covers one scenario.
module tb_k005297_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk4m_n;
  logic        clk2m_n;
  logic [19:0] rot_n;
  logic        run;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [2:0]  gnt;
  logic        stb;
  logic        busy;
  logic        stoprq_n;

  int tests = 0;
  int fails = 0;

  k005297_slot_scheduler #(.IDLE_FRAMES(2), .CNT_W(4)) dut (
    .i_MCLK           (clk),
    .i_MRST_n         (rst_n),
    .i_CLK4M_PCEN_n   (clk4m_n),
    .i_CLK2M_PCEN_n   (clk2m_n),
    .i_ROT20_n        (rot_n),
    .i_SYS_RUN_FLAG   (run),
    .i_REQ            (req),
    .i_LOCK           (lock),
    .o_GNT            (gnt),
    .o_SLOT_STB       (stb),
    .o_BUSY           (busy),
    .o_CLK2M_STOPRQ_n (stoprq_n)
  );

  always #5 clk = ~clk;

  // One i_MCLK cycle at rotator position p (negative = all ones); outputs are sampled 1 unit after the edge.
  task automatic step(input int p, input logic t2m, input logic t4m);
    rot_n   = (p < 0) ? 20'hFFFFF : ~(20'd1 << p);
    clk2m_n = ~t2m;
    clk4m_n = ~t4m;
    @(posedge clk);
    #1;
    clk2m_n = 1'b1;
    clk4m_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 3'b000; lock = 3'b000; run = 1'b1;
    step(-1, 1'b0, 1'b0);
    step(-1, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (gnt !== 3'b000) begin fails++; $display("[TB] FAIL reset_gnt: got %b want 000", gnt); end
    tests++; if (stb !== 1'b0) begin fails++; $display("[TB] FAIL reset_stb: got %b want 0", stb); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tests++; if (stoprq_n !== 1'b1) begin fails++; $display("[TB] FAIL reset_stoprq: got %b want 1", stoprq_n); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt;
    int stb_cnt;
    do_reset();
    req = 3'b110;
    step(3, 1'b1, 1'b0);
    step(4, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b000) begin fails++; $display("[TB] FAIL rr_pre_gnt: got %b want 000", gnt); end
    stb_cnt = 0;
    for (int p = 5; p <= 17; p++) begin
      step(p, 1'b1, 1'b0);
      exp_gnt = (p < 10) ? 3'b010 : (p < 15) ? 3'b100 : 3'b010;
      if (stb === 1'b1) stb_cnt++;
      tests++; if (gnt !== exp_gnt) begin fails++; $display("[TB] FAIL rr_gnt pos %0d: got %b want %b", p, gnt, exp_gnt); end
      tests++; if (stb !== (p % 5 == 0)) begin fails++; $display("[TB] FAIL rr_stb pos %0d: got %b want %b", p, stb, (p % 5 == 0)); end
    end
    tests++; if (stb_cnt != 3) begin fails++; $display("[TB] FAIL rr_stb_count: got %0d want 3", stb_cnt); end
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL rr_busy: got %b want 1", busy); end
    req = 3'b000;
    step(18, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b000) begin fails++; $display("[TB] FAIL rr_drop_gnt: got %b want 000", gnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rr_drop_busy: got %b want 0", busy); end
  endtask

  task automatic test_dma_priority();
    do_reset();
    req = 3'b011;
    step(0, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b001 || stb !== 1'b1) begin fails++; $display("[TB] FAIL dma_win: got gnt %b stb %b want 001 1", gnt, stb); end
    for (int p = 1; p <= 4; p++) step(p, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b001 || stb !== 1'b0) begin fails++; $display("[TB] FAIL dma_hold: got gnt %b stb %b want 001 0", gnt, stb); end
    req = 3'b010;
    step(5, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b010 || stb !== 1'b1) begin fails++; $display("[TB] FAIL dma_handoff: got gnt %b stb %b want 010 1", gnt, stb); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 3'b001;
    step(0, 1'b1, 1'b0);
    for (int p = 1; p <= 4; p++) step(p, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b001 || stb !== 1'b1) begin fails++; $display("[TB] FAIL b2b_regrant: got gnt %b stb %b want 001 1", gnt, stb); end
  endtask

  task automatic test_lock();
    do_reset();
    req = 3'b010;
    step(10, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b010 || stb !== 1'b1) begin fails++; $display("[TB] FAIL lock_grant: got gnt %b stb %b want 010 1", gnt, stb); end
    lock = 3'b010;
    for (int p = 11; p <= 14; p++) step(p, 1'b1, 1'b0);
    req = 3'b011;
    step(15, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b010 || stb !== 1'b0) begin fails++; $display("[TB] FAIL lock_keep15: got gnt %b stb %b want 010 0", gnt, stb); end
    for (int p = 16; p <= 19; p++) step(p, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b010 || stb !== 1'b0) begin fails++; $display("[TB] FAIL lock_keep0: got gnt %b stb %b want 010 0", gnt, stb); end
    lock = 3'b000;
    for (int p = 1; p <= 4; p++) step(p, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b010) begin fails++; $display("[TB] FAIL lock_midslot: got %b want 010", gnt); end
    step(5, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b001 || stb !== 1'b1) begin fails++; $display("[TB] FAIL lock_release: got gnt %b stb %b want 001 1", gnt, stb); end
  endtask

  task automatic test_idle_stop();
    do_reset();
    for (int p = 0; p <= 19; p++) step(p, 1'b1, 1'b0);
    tests++; if (stoprq_n !== 1'b1) begin fails++; $display("[TB] FAIL idle_first_frame: got %b want 1", stoprq_n); end
    for (int p = 0; p <= 18; p++) step(p, 1'b1, 1'b0);
    tests++; if (stoprq_n !== 1'b1) begin fails++; $display("[TB] FAIL idle_before_second: got %b want 1", stoprq_n); end
    step(19, 1'b1, 1'b0);
    tests++; if (stoprq_n !== 1'b0) begin fails++; $display("[TB] FAIL idle_stop: got %b want 0", stoprq_n); end
    req = 3'b100;
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    tests++; if (stoprq_n !== 1'b0) begin fails++; $display("[TB] FAIL stop_no_wake: got %b want 0", stoprq_n); end
    step(5, 1'b1, 1'b0);
    tests++; if (stoprq_n !== 1'b0 || gnt !== 3'b000) begin fails++; $display("[TB] FAIL stop_tick_ignored: got stoprq %b gnt %b want 0 000", stoprq_n, gnt); end
    step(6, 1'b0, 1'b1);
    tests++; if (stoprq_n !== 1'b1 || gnt !== 3'b000) begin fails++; $display("[TB] FAIL wake: got stoprq %b gnt %b want 1 000", stoprq_n, gnt); end
    step(10, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b100 || stb !== 1'b1) begin fails++; $display("[TB] FAIL wake_grant: got gnt %b stb %b want 100 1", gnt, stb); end
  endtask

  task automatic test_invalid_rot();
    int stb_cnt;
    do_reset();
    req = 3'b010;
    step(0, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b010) begin fails++; $display("[TB] FAIL inv_grant: got %b want 010", gnt); end
    step(1, 1'b1, 1'b0);
    stb_cnt = 0;
    req = 3'b011;
    for (int i = 0; i < 10; i++) begin
      step(-1, 1'b1, 1'b0);
      if (stb === 1'b1) stb_cnt++;
    end
    tests++; if (gnt !== 3'b010 || stb_cnt != 0) begin fails++; $display("[TB] FAIL inv_no_arb: got gnt %b strobes %0d want 010 0", gnt, stb_cnt); end
    rst_n = 1'b0;
    step(-1, 1'b0, 1'b0);
    tests++; if (gnt !== 3'b000 || busy !== 1'b0 || stb !== 1'b0) begin fails++; $display("[TB] FAIL inv_reset: got gnt %b busy %b stb %b want 000 0 0", gnt, busy, stb); end
    rst_n = 1'b1;
  endtask

  task automatic test_sys_run();
    do_reset();
    req = 3'b001;
    step(0, 1'b1, 1'b0);
    run = 1'b0;
    step(1, 1'b0, 1'b0);
    tests++; if (gnt !== 3'b001) begin fails++; $display("[TB] FAIL run_no_enable: got %b want 001", gnt); end
    step(2, 1'b1, 1'b0);
    tests++; if (gnt !== 3'b000 || busy !== 1'b0) begin fails++; $display("[TB] FAIL run_low_tick: got gnt %b busy %b want 000 0", gnt, busy); end
    run = 1'b1;
    req = 3'b000;
    step(19, 1'b1, 1'b0);
    step(19, 1'b1, 1'b0);
    tests++; if (stoprq_n !== 1'b0) begin fails++; $display("[TB] FAIL run_stop_pending: got %b want 0", stoprq_n); end
    run = 1'b0;
    step(-1, 1'b0, 1'b1);
    tests++; if (stoprq_n !== 1'b1 || gnt !== 3'b000) begin fails++; $display("[TB] FAIL run_low_wake: got stoprq %b gnt %b want 1 000", stoprq_n, gnt); end
    run = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clk4m_n = 1'b1; clk2m_n = 1'b1; rot_n = 20'hFFFFF;
    run = 1'b1; req = 3'b000; lock = 3'b000;
    test_reset();
    test_round_robin();
    test_dma_priority();
    test_back_to_back();
    test_lock();
    test_idle_stop();
    test_invalid_rot();
    test_sys_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
